// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage core: stalls, flushes, forwarding and memory-timeout halt.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCycles
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, nextState;
  logic [7:0] waitCnt;
  logic [7:0] waitNext;
  logic       lwStall;
  logic       memWait;
  logic       frozen;

  function automatic logic [1:0] fwdSel(input logic [4:0] rsE, input logic [4:0] rdMem,
                                        input logic wrMem, input logic [4:0] rdWb,
                                        input logic wrWb);
    if (wrMem && rdMem != 5'd0 && rdMem == rsE)
      return 2'b10;
    else if (wrWb && rdWb != 5'd0 && rdWb == rsE)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lwStall  = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign memWait  = MemReqM && !MemReadyM;
  assign frozen   = (state == RUN && memWait) || (state == MEMWAIT && !MemReadyM);
  assign waitNext = (waitCnt == 8'hFF) ? 8'hFF : waitCnt + 8'd1;

  assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= nextState;
  end

  // waitCnt holds the number of wait cycles already spent on the current access
  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (memWait) nextState = (TIMEOUT <= 8'd1) ? HALT : MEMWAIT;
      MEMWAIT: begin
        if (MemReadyM)
          nextState = RUN;
        else if (waitNext >= TIMEOUT)
          nextState = HALT;
      end
      HALT:    nextState = HALT;
      default: nextState = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state == HALT || frozen) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lwStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= 8'd0;
      MemErr  <= 1'b0;
    end else begin
      case (state)
        RUN:     waitCnt <= memWait ? 8'd1 : 8'd0;
        MEMWAIT: waitCnt <= waitNext;
        default: waitCnt <= waitCnt;
      endcase
      if (nextState == HALT)
        MemErr <= 1'b1;
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= 32'd0;
      flushCnt <= 32'd0;
    end else begin
      if (StallF) stallCnt <= stallCnt + 32'd1;
      if (FlushE) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign StallCycles = stallCnt;
  assign FlushCycles = flushCnt;
`else
  assign StallCycles = 32'd0;
  assign FlushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, multi-cycle sequences and random traffic vs. a reference model.
module tb_pipeline_hazard_ctrl;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCycles, FlushCycles;
  logic [6:0]  ctlOut;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] CTL_RST    = 7'b0000111;
  localparam logic [6:0] CTL_FREEZE = 7'b1111001;
  localparam logic [6:0] CTL_BRANCH = 7'b0000110;
  localparam logic [6:0] CTL_LWSTL  = 7'b1100010;
  localparam logic [6:0] CTL_NONE   = 7'b0000000;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  always #5 clk = ~clk;
  assign ctlOut = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       ld, pc, rwM, rwW;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, input logic ld, pc,
                              input logic [4:0] rdM, input logic rwM, input logic [4:0] rdW,
                              input logic rwW, input logic [6:0] ctl, input logic [1:0] fa, fb);
    vec_t v;
    v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E; v.rdE = rdE;
    v.ld = ld; v.pc = pc; v.rdM = rdM; v.rwM = rwM; v.rdW = rdW; v.rwW = rwW;
    v.ctl = ctl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic logic [1:0] refFwd(input logic [4:0] rs, rdm, rdw, input logic wm, ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic applyVec(input vec_t v);
    Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E; RdE = v.rdE;
    ResultSrcE0 = v.ld; PCSrcE = v.pc; RdM = v.rdM; RegWriteM = v.rwM;
    RdW = v.rdW; RegWriteW = v.rwW;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_ctl", 32'(ctlOut), 32'(CTL_RST));
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctl", 32'(ctlOut), 32'(CTL_NONE));
    chk("post_rst_memerr", 32'(MemErr), 32'd0);
    chk("post_rst_stallcyc", StallCycles, 32'd0);
    chk("post_rst_flushcyc", FlushCycles, 32'd0);
    nextCycle();
  endtask

  int   waits;
  bit   halted;
  logic [6:0] eCtl;
  logic       lw, frz;
  int   mStall, mFlush;

  initial begin
    rst = 1'b1;
    idle();
    #1;
    doReset();

    // table of single-cycle behaviour from RUN
    vecs[0] = mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, CTL_LWSTL,  2'b00, 2'b00);
    vecs[1] = mk(0, 0, 3, 0, 0, 0, 0, 3, 1, 3, 1, CTL_NONE,   2'b10, 2'b00);
    vecs[2] = mk(0, 0, 3, 0, 0, 0, 0, 0, 1, 3, 1, CTL_NONE,   2'b01, 2'b00);
    vecs[3] = mk(0, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, CTL_BRANCH, 2'b00, 2'b00);
    vecs[4] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, CTL_NONE,   2'b00, 2'b00);
    vecs[5] = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, CTL_NONE,   2'b00, 2'b00);
    vecs[6] = mk(0, 0, 4, 4, 0, 0, 0, 4, 0, 4, 1, CTL_NONE,   2'b01, 2'b01);
    vecs[7] = mk(0, 0, 6, 6, 0, 0, 0, 6, 1, 6, 0, CTL_NONE,   2'b10, 2'b10);
    vecs[8] = mk(1, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, CTL_LWSTL,  2'b00, 2'b00);
    vecs[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, CTL_NONE,   2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      applyVec(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctlOut), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_fa", i), 32'(ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(ForwardBE), 32'(vecs[i].fb));
      nextCycle();
    end

    // load-use: one bubble, then the load forwards from W
    idle(); ResultSrcE0 = 1; RdE = 5; Rs1D = 5;
    @(negedge clk); chk("lu_stall", 32'(ctlOut), 32'(CTL_LWSTL)); nextCycle();
    idle(); RdM = 5; RegWriteM = 1;
    @(negedge clk); chk("lu_bubble", 32'(ctlOut), 32'(CTL_NONE)); nextCycle();
    idle(); RdW = 5; RegWriteW = 1; Rs1E = 5;
    @(negedge clk); chk("lu_fwdW", 32'(ForwardAE), 32'b01); nextCycle();

    // 3-cycle memory wait with a branch held in frozen E
    idle(); MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("mw_freeze%0d", i), 32'(ctlOut), 32'(CTL_FREEZE)); nextCycle();
    end
    MemReadyM = 1;
    @(negedge clk); chk("mw_done_branch", 32'(ctlOut), 32'(CTL_BRANCH)); nextCycle();
    idle();
    @(negedge clk); chk("mw_run", 32'(ctlOut), 32'(CTL_NONE)); chk("mw_memerr", 32'(MemErr), 0);
    nextCycle();

    // single-cycle access then a one-cycle wait
    MemReqM = 1; MemReadyM = 1;
    @(negedge clk); chk("sc_nofreeze", 32'(ctlOut), 32'(CTL_NONE)); nextCycle();
    MemReadyM = 0;
    @(negedge clk); chk("sc_wait1", 32'(ctlOut), 32'(CTL_FREEZE)); nextCycle();
    MemReadyM = 1; MemReqM = 0;
    @(negedge clk); chk("sc_release", 32'(ctlOut), 32'(CTL_NONE)); nextCycle();

    // timeout into HALT
    idle(); MemReqM = 1;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk);
      chk($sformatf("to_freeze%0d", i), 32'(ctlOut), 32'(CTL_FREEZE));
      chk($sformatf("to_memerr%0d", i), 32'(MemErr), 0);
      nextCycle();
    end
    idle(); MemReadyM = 1; RegWriteM = 1; RdM = 8; Rs1E = 8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("halt_ctl%0d", i), 32'(ctlOut), 32'(CTL_FREEZE));
      chk($sformatf("halt_memerr%0d", i), 32'(MemErr), 1);
      chk($sformatf("halt_fwd%0d", i), 32'(ForwardAE), 32'b10);
      nextCycle();
    end
    doReset();

`ifdef PIPE_PERF_EN
    idle(); ResultSrcE0 = 1; RdE = 2; Rs2D = 2;
    nextCycle(); nextCycle();
    idle(); PCSrcE = 1;
    nextCycle();
    idle();
    @(negedge clk);
    chk("perf_stall", StallCycles, 32'd2);
    chk("perf_flush", FlushCycles, 32'd3);
    nextCycle();
`endif

    // random traffic against the reference model
    doReset();
    waits = 0; halted = 0; mStall = 0; mFlush = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 29) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3));  RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      ResultSrcE0 = ($urandom_range(0, 2) == 0); PCSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM = $urandom_range(0, 1); RegWriteW = $urandom_range(0, 1);
      MemReqM = $urandom_range(0, 1); MemReadyM = ($urandom_range(0, 2) != 0);

      lw  = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      frz = (waits > 0 || MemReqM) && !MemReadyM;
      if (rst)          eCtl = CTL_RST;
      else if (halted)  eCtl = CTL_FREEZE;
      else if (frz)     eCtl = CTL_FREEZE;
      else if (PCSrcE)  eCtl = CTL_BRANCH;
      else if (lw)      eCtl = CTL_LWSTL;
      else              eCtl = CTL_NONE;

      @(negedge clk);
      chk("rnd_ctl", 32'(ctlOut), 32'(eCtl));
      chk("rnd_fa", 32'(ForwardAE), 32'(refFwd(Rs1E, RdM, RdW, RegWriteM, RegWriteW)));
      chk("rnd_fb", 32'(ForwardBE), 32'(refFwd(Rs2E, RdM, RdW, RegWriteM, RegWriteW)));
      chk("rnd_memerr", 32'(MemErr), 32'(halted));
`ifdef PIPE_PERF_EN
      chk("rnd_stallcyc", StallCycles, 32'(mStall));
      chk("rnd_flushcyc", FlushCycles, 32'(mFlush));
`else
      chk("rnd_perf_off", StallCycles | FlushCycles, 32'd0);
`endif
      nextCycle();

      if (rst) begin
        halted = 0; waits = 0; mStall = 0; mFlush = 0;
      end else begin
        mStall += int'(eCtl[6]);
        mFlush += int'(eCtl[1]);
        if (!halted) begin
          if (frz) begin
            waits++;
            if (waits >= MT) halted = 1;
          end else begin
            waits = 0;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
